// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding 7-segment decoders.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

`ifdef BIN2BCD_BLANK_EN
    // Digits above the most significant non-zero digit become 4'hF; digit 0 always shows.
    function automatic logic [BW-1:0] blank_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          seen;
        r    = v;
        seen = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (v[4*k +: 4] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            if (!seen) begin
                r[4*k +: 4] = 4'hF;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [BW-1:0] BCD_RST = blank_digits({BW{1'b0}});
`else
    localparam logic [BW-1:0] BCD_RST = {BW{1'b0}};
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic [WIDTH-1:0]  shift_r;
    logic [BW-1:0]     scratch_r;
    logic [CW-1:0]     cnt_r;
    logic              sticky_r;
    logic              busy_r;
    logic              done_r;
    logic [BW-1:0]     bcd_r;
    logic              overflow_r;

    logic              load_s;
    logic              step_s;
    logic              last_s;
    logic [BW-1:0]     adj_s;
    logic              bit_out_s;
    logic [BW-1:0]     next_scratch_s;
    logic              ovf_s;
    logic [BW-1:0]     result_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (cnt_r == CW'(1)) begin
                    last_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // One add-3/shift step; the bit leaving the top digit marks a result beyond DIGITS digits.
    always_comb begin
        adj_s          = add3_digits(scratch_r);
        bit_out_s      = adj_s[BW-1];
        next_scratch_s = {adj_s[BW-2:0], shift_r[WIDTH-1]};
        ovf_s          = sticky_r | bit_out_s;
        if (ovf_s) begin
            result_s = NINES;
        end else begin
`ifdef BIN2BCD_BLANK_EN
            result_s = blank_digits(next_scratch_s);
`else
            result_s = next_scratch_s;
`endif
        end
    end

    // Scratch datapath and held outputs; bcd/overflow only move on completion or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {WIDTH{1'b0}};
            scratch_r  <= {BW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            sticky_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= BCD_RST;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load_s) begin
                shift_r   <= bin;
                scratch_r <= {BW{1'b0}};
                sticky_r  <= 1'b0;
                cnt_r     <= CW'(WIDTH);
                busy_r    <= 1'b1;
            end else if (step_s) begin
                shift_r   <= shift_r << 1;
                scratch_r <= next_scratch_s;
                sticky_r  <= ovf_s;
                cnt_r     <= cnt_r - CW'(1);
                if (last_s) begin
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    bcd_r      <= result_s;
                    overflow_r <= ovf_s;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed vectors push expected {overflow,bcd}; a monitor pops on done.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, start2, start3;
    logic [7:0]  bin, bin2;
    logic [0:0]  bin3;
    logic        busy, done, overflow;
    logic [11:0] bcd;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;
    logic        busy3, done3, overflow3;
    logic [3:0]  bcd3;

    int n_chk  = 0;
    int n_fail = 0;
    logic [12:0] exp_q[$];
    logic [8:0]  exp2_q[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow));

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2));

    bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(overflow3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] sel(input logic [11:0] plain, input logic [11:0] blanked);
        return BLANK ? blanked : plain;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one accepted start on dut1 and record its expected response.
    task automatic issue(input logic [7:0] v, input logic [11:0] e_bcd, input logic e_ovf);
        bin   = v;
        start = 1'b1;
        exp_q.push_back({e_ovf, e_bcd});
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, output int busy_cnt);
        int lat;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        logic [12:0] e;
        logic [8:0]  e2;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bcd", 32'(bcd), 32'(e[11:0]));
                chk("overflow", 32'(overflow), 32'(e[12]));
            end
        end
        if (done2) begin
            if (exp2_q.size() == 0) begin
                chk("unexpected_done2", 32'd1, 32'd0);
            end else begin
                e2 = exp2_q.pop_front();
                chk("bcd2", 32'(bcd2), 32'(e2[7:0]));
                chk("overflow2", 32'(overflow2), 32'(e2[8]));
            end
        end
    end

    initial begin
        int bc;
        int lat;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; start3 = 1'b0;
        bin = 8'd0; bin2 = 8'd0; bin3 = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'(sel(12'h000, 12'hFF0)));
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_bcd2", 32'(bcd2), 32'(BLANK ? 8'hF0 : 8'h00));
        chk("rst_bcd3", 32'(bcd3), 32'd0);
        rst = 1'b0;
        step();

        // Zero input: busy for exactly 8 sampled cycles.
        issue(8'd0, sel(12'h000, 12'hFF0), 1'b0);
        wait_done("zero", 8, bc);
        chk("zero_busy_cycles", 32'(bc), 32'd8);
        step();
        chk("zero_done_one_cycle", 32'(done), 32'd0);

        issue(8'd255, sel(12'h255, 12'h255), 1'b0);
        wait_done("v255", 8, bc);
        step();

        // start held high: bin change mid-conversion ignored, done-cycle start accepted.
        bin   = 8'd209;
        start = 1'b1;
        exp_q.push_back({1'b0, sel(12'h209, 12'h209)});
        step();
        bin = 8'd99;
        wait_done("held1", 8, bc);
        bin = 8'd58;
        exp_q.push_back({1'b0, sel(12'h058, 12'hF58)});
        step();
        start = 1'b0;
        bin   = 8'd0;
        chk("held_reaccept_busy", 32'(busy), 32'd1);
        wait_done("held2", 8, bc);
        step();
        chk("held_done_one_cycle", 32'(done), 32'd0);

        // start pulse while busy with a new bin has no effect.
        issue(8'd100, sel(12'h100, 12'h100), 1'b0);
        step();
        step();
        bin   = 8'd37;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("busy_ignore", 5, bc);
        repeat (12) step();
        chk("busy_ignore_hold_bcd", 32'(bcd), 32'h100);
        chk("busy_ignore_idle", 32'(busy), 32'd0);

        // Reset mid-conversion aborts without a done pulse.
        bin   = 8'd123;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'(sel(12'h000, 12'hFF0)));
        rst = 1'b0;
        repeat (12) step();
        issue(8'd42, sel(12'h042, 12'hF42), 1'b0);
        wait_done("after_abort", 8, bc);
        step();

        issue(8'd7, sel(12'h007, 12'hFF7), 1'b0);
        wait_done("v7", 8, bc);
        step();

        // Two-digit instance: saturation then recovery.
        bin2   = 8'd150;
        start2 = 1'b1;
        exp2_q.push_back({1'b1, 8'h99});
        step();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 40) begin step(); lat++; end
        chk("d2_ovf_latency", 32'(lat), 32'd8);
        step();
        bin2   = 8'd42;
        start2 = 1'b1;
        exp2_q.push_back({1'b0, 8'h42});
        step();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 40) begin step(); lat++; end
        chk("d2_42_latency", 32'(lat), 32'd8);
        step();

        // WIDTH=1: done one edge after acceptance.
        bin3   = 1'b1;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("w1_busy", 32'(busy3), 32'd1);
        chk("w1_not_done", 32'(done3), 32'd0);
        step();
        chk("w1_done", 32'(done3), 32'd1);
        chk("w1_bcd", 32'(bcd3), 32'h1);
        chk("w1_ovf", 32'(overflow3), 32'd0);
        chk("w1_idle", 32'(busy3), 32'd0);

        repeat (3) step();
        chk("queues_drained", 32'(exp_q.size() + exp2_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
